// File: rtl/modexp_pkg.sv
// Shared types and defaults for the modexp step sequencer.
//   state_t : sequencer FSM states
//   DW_DEF  : default datapath word width
//   EW_DEF  : default exponent width
//   clog2() : ceiling log2, used to size the bit index
package modexp_pkg;

  localparam int unsigned DW_DEF = 64;
  localparam int unsigned EW_DEF = 8;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    ISSUE = 2'd1,
    DONE  = 2'd2
  } state_t;

  // Smallest r with 2**r >= v; loop bound keeps it a plain constant function.
  function automatic int unsigned clog2(input int unsigned v);
    int unsigned r;
    r = 0;
    for (int unsigned i = 0; i < 32; i++) begin
      if ((64'd1 << i) < 64'(v)) r = i + 1;
    end
    return r;
  endfunction

endpackage

// File: rtl/modexp_exp_shreg.sv
// Exponent shift register: loads EW bits, presents the MSB, shifts left on advance.
//   clk, rst  : clock, synchronous active-high reset
//   load      : capture load_val (takes precedence over advance)
//   clear     : drop the held exponent (cancelled run)
//   advance   : shift one bit towards the MSB
//   load_val  : exponent to capture
//   msb       : current exponent bit, straight from the register
module modexp_exp_shreg
  import modexp_pkg::*;
#(
  parameter int unsigned EW = EW_DEF
) (
  input  logic          clk,
  input  logic          rst,
  input  logic          load,
  input  logic          clear,
  input  logic          advance,
  input  logic [EW-1:0] load_val,
  output logic          msb
);

  logic [EW-1:0] sr;

  // After EW advances the register is empty, so e_bit reads 0 outside a run.
  always_ff @(posedge clk) begin
    if (rst || clear) begin
      sr <= '0;
    end else if (load) begin
      sr <= load_val;
    end else if (advance) begin
      sr <= {sr[EW-2:0], 1'b0};
    end
  end

  assign msb = sr[EW-1];

endmodule

// File: rtl/modexp_seq.sv
// Sequencer for a bit-serial square-and-multiply modexp datapath.
// Issues one step per exponent bit (MSB first), waits for each ack, captures
// the final z and offers it on a valid/ready port.
//   clk, rst            : clock, synchronous active-high reset
//   start, exp_in       : begin a run with this exponent (IDLE only)
//   abort               : cancel the run, no result
//   step_req, step_ack  : per-step handshake with the datapath
//   e_bit, z_init       : current exponent bit, first-step flag
//   z_in                : datapath z, sampled on req&ack
//   res_out, res_valid,
//   res_ready           : result port
//   busy                : not in IDLE
//   trig                : one-cycle pulse on the first step request of a run
//   step_cnt            : index of the bit being issued
module modexp_seq
  import modexp_pkg::*;
#(
  parameter int unsigned DW = DW_DEF,
  parameter int unsigned EW = EW_DEF,
  parameter int unsigned IW = clog2(EW)
) (
  input  logic          clk,
  input  logic          rst,
  input  logic          start,
  input  logic [EW-1:0] exp_in,
  input  logic          abort,
  output logic          step_req,
  input  logic          step_ack,
  output logic          e_bit,
  output logic          z_init,
  input  logic [DW-1:0] z_in,
  output logic [DW-1:0] res_out,
  output logic          res_valid,
  input  logic          res_ready,
  output logic          busy,
  output logic          trig,
  output logic [IW-1:0] step_cnt
);

  state_t        state;
  logic [IW-1:0] bit_idx;
  logic          sr_load;
  logic          sr_adv;

  // step_req is high for the whole ISSUE state, so an ack in ISSUE is a handshake.
  assign sr_load  = (state == IDLE) && start && !abort;
  assign sr_adv   = (state == ISSUE) && step_ack && !abort;
  assign step_cnt = bit_idx;

  modexp_exp_shreg #(
    .EW(EW)
  ) u_shreg (
    .clk     (clk),
    .rst     (rst),
    .load    (sr_load),
    .clear   (abort),
    .advance (sr_adv),
    .load_val(exp_in),
    .msb     (e_bit)
  );

  // FSM plus registered outputs; abort outranks ack and ready.
  always_ff @(posedge clk) begin
    if (rst) begin
      state     <= IDLE;
      bit_idx   <= '0;
      z_init    <= 1'b0;
      step_req  <= 1'b0;
      res_valid <= 1'b0;
      res_out   <= '0;
      busy      <= 1'b0;
      trig      <= 1'b0;
    end else if (abort) begin
      state     <= IDLE;
      bit_idx   <= '0;
      z_init    <= 1'b0;
      step_req  <= 1'b0;
      res_valid <= 1'b0;
      busy      <= 1'b0;
      trig      <= 1'b0;
    end else begin
      trig <= 1'b0;
      case (state)
        IDLE: begin
          if (start) begin
            state    <= ISSUE;
            bit_idx  <= IW'(EW - 1);
            z_init   <= 1'b1;
            step_req <= 1'b1;
            busy     <= 1'b1;
            trig     <= 1'b1;
          end
        end
        ISSUE: begin
          if (step_ack) begin
            z_init <= 1'b0;
            if (bit_idx != '0) begin
              bit_idx <= bit_idx - IW'(1);
            end else begin
              res_out   <= z_in;
              state     <= DONE;
              step_req  <= 1'b0;
              res_valid <= 1'b1;
            end
          end
        end
        DONE: begin
          if (res_ready) begin
            state     <= IDLE;
            res_valid <= 1'b0;
            busy      <= 1'b0;
          end
        end
        default: begin
          state     <= IDLE;
          step_req  <= 1'b0;
          res_valid <= 1'b0;
          busy      <= 1'b0;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_modexp_seq.sv
// Bench for modexp_seq: a square-and-multiply datapath stub with programmable
// stalls, a scoreboard of expected results, and a cycle monitor.
module tb_modexp_seq;

  localparam int unsigned DW = 64;
  localparam int unsigned EW = 8;
  localparam int unsigned IW = 3;
  localparam logic [63:0] N_MOD = 64'hbe3a20ff7a7d7fca;
  localparam logic [63:0] X_BASE = 64'hf01f2e724ac0ab35;

  logic          clk = 1'b0;
  logic          rst = 1'b1;
  logic          start = 1'b0;
  logic [EW-1:0] exp_in = '0;
  logic          abort = 1'b0;
  logic          step_req;
  logic          step_ack;
  logic          e_bit;
  logic          z_init;
  logic [DW-1:0] z_in;
  logic [DW-1:0] res_out;
  logic          res_valid;
  logic          res_ready = 1'b1;
  logic          busy;
  logic          trig;
  logic [IW-1:0] step_cnt;

  int n_cmp = 0;
  int n_err = 0;

  modexp_seq #(.DW(DW), .EW(EW)) dut (
    .clk      (clk),
    .rst      (rst),
    .start    (start),
    .exp_in   (exp_in),
    .abort    (abort),
    .step_req (step_req),
    .step_ack (step_ack),
    .e_bit    (e_bit),
    .z_init   (z_init),
    .z_in     (z_in),
    .res_out  (res_out),
    .res_valid(res_valid),
    .res_ready(res_ready),
    .busy     (busy),
    .trig     (trig),
    .step_cnt (step_cnt)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_cmp++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got %h expected %h", tag, got, exp);
    end
  endtask

  function automatic logic [63:0] mulmod(input logic [63:0] a, input logic [63:0] b,
                                         input logic [63:0] m);
    logic [127:0] p;
    p = {64'd0, a} * {64'd0, b};
    return 64'(p % {64'd0, m});
  endfunction

  // Right-to-left binary exponentiation: a different walk from the stub's.
  function automatic logic [63:0] model(input logic [EW-1:0] e);
    logic [63:0] r;
    logic [63:0] b;
    r = 64'd1;
    b = X_BASE % N_MOD;
    for (int i = 0; i < int'(EW); i++) begin
      if (e[i]) r = mulmod(r, b, N_MOD);
      b = mulmod(b, b, N_MOD);
    end
    return r;
  endfunction

  // Datapath stub: z = base^2 * (e_bit ? x : 1) mod n, base = 1 on the first step.
  logic [63:0] z_reg = 64'd0;
  logic [63:0] z_base;
  logic [63:0] z_sq;
  assign z_base = z_init ? 64'd1 : z_reg;
  assign z_sq   = mulmod(z_base, z_base, N_MOD);
  assign z_in   = e_bit ? mulmod(z_sq, X_BASE, N_MOD) : z_sq;

  // Ack generation: tied high, fixed stall, or 0..5 random stall cycles.
  logic tie_ack = 1'b0;
  logic rand_stall = 1'b0;
  int   fix_stall = 1;
  logic ack_r = 1'b0;
  int   wait_cnt = 0;
  assign step_ack = tie_ack | ack_r;

  always @(posedge clk) begin
    int s;
    s = rand_stall ? int'($urandom_range(5, 0)) : fix_stall;
    if (step_req && step_ack) z_reg <= z_in;
    if (rst || !step_req) begin
      ack_r    <= 1'b0;
      wait_cnt <= (s > 0) ? s - 1 : 0;
    end else if (ack_r) begin
      ack_r    <= (s == 0);
      wait_cnt <= (s > 0) ? s - 1 : 0;
    end else if (wait_cnt == 0) begin
      ack_r <= 1'b1;
    end else begin
      wait_cnt <= wait_cnt - 1;
    end
  end

  // Monitor: logs handshakes, counts trig pulses, checks stall stability, scores results.
  logic [63:0] sb[$];
  int          ack_total = 0;
  int          trig_total = 0;
  logic        e_log[256];
  logic        zi_log[256];
  logic [IW-1:0] cnt_log[256];
  logic        prev_req = 1'b0;
  logic        prev_ack = 1'b0;
  logic [IW+1:0] prev_vec = '0;

  always @(negedge clk) begin
    if (!rst) begin
      if (prev_req && !prev_ack && step_req)
        chk("stall_hold", 64'({e_bit, z_init, step_cnt}), 64'(prev_vec));
      if (step_req && step_ack) begin
        e_log[ack_total & 255]   = e_bit;
        zi_log[ack_total & 255]  = z_init;
        cnt_log[ack_total & 255] = step_cnt;
        ack_total++;
      end
      if (trig) trig_total++;
      if (res_valid && res_ready) begin
        if (sb.size() == 0) chk("unexpected_result", res_out, 64'hx);
        else chk("result", res_out, sb.pop_front());
      end
    end
    prev_req = step_req;
    prev_ack = step_ack;
    prev_vec = {e_bit, z_init, step_cnt};
  end

  task automatic cyc();
    @(posedge clk);
    #1;
  endtask

  task automatic run_start(input logic [EW-1:0] e, input bit push);
    cyc();
    start  = 1'b1;
    exp_in = e;
    if (push) sb.push_back(model(e));
    cyc();
    start = 1'b0;
  endtask

  task automatic wait_idle(input string tag);
    int n;
    n = 0;
    while ((busy || res_valid) && n < 400) begin
      cyc();
      n++;
    end
    if (n >= 400) chk(tag, 64'd0, 64'd1);
  endtask

  task automatic wait_acks(input int target, input string tag);
    int n;
    n = 0;
    while (ack_total < target && n < 400) begin
      cyc();
      n++;
    end
    if (n >= 400) chk(tag, 64'(ack_total), 64'(target));
  endtask

  task automatic chk_reset_outs(input string tag);
    chk({tag, "_req"}, 64'(step_req), 64'd0);
    chk({tag, "_valid"}, 64'(res_valid), 64'd0);
    chk({tag, "_busy"}, 64'(busy), 64'd0);
    chk({tag, "_trig"}, 64'(trig), 64'd0);
    chk({tag, "_ebit"}, 64'(e_bit), 64'd0);
    chk({tag, "_zinit"}, 64'(z_init), 64'd0);
    chk({tag, "_cnt"}, 64'(step_cnt), 64'd0);
    chk({tag, "_res"}, res_out, 64'd0);
  endtask

  initial begin
    int base;
    int tbase;
    int n;
    logic [EW-1:0] a5;
    a5 = 8'hA5;

    repeat (3) cyc();
    chk_reset_outs("reset");
    rst = 1'b0;

    // Test 1: one-cycle ack delay, exp A5; bit sequence and z_init pattern.
    fix_stall = 1;
    base = ack_total;
    run_start(a5, 1'b1);
    wait_idle("t1_timeout");
    chk("t1_acks", 64'(ack_total - base), 64'd8);
    for (int i = 0; i < 8; i++) begin
      chk($sformatf("t1_ebit%0d", i), 64'(e_log[(base + i) & 255]), 64'(a5[7 - i]));
      chk($sformatf("t1_zinit%0d", i), 64'(zi_log[(base + i) & 255]), 64'(i == 0));
      chk($sformatf("t1_cnt%0d", i), 64'(cnt_log[(base + i) & 255]), 64'(7 - i));
    end

    // Test 2: ack tied high, exp FF; latency, trig, ack count.
    tie_ack = 1'b1;
    base  = ack_total;
    tbase = trig_total;
    run_start(8'hFF, 1'b1);
    n = 1;
    while (!res_valid && n < 20) begin
      cyc();
      n++;
    end
    chk("t2_latency", 64'(n), 64'd9);
    wait_idle("t2_timeout");
    chk("t2_trig", 64'(trig_total - tbase), 64'd1);
    chk("t2_acks", 64'(ack_total - base), 64'd8);
    tie_ack = 1'b0;

    // Test 3: random stalls with several exponents.
    rand_stall = 1'b1;
    foreach (sb[i]) chk("t3_sb_empty", 64'(sb.size()), 64'd0);
    run_start(8'h5B, 1'b1);
    wait_idle("t3a_timeout");
    run_start(8'h00, 1'b1);
    wait_idle("t3b_timeout");
    run_start(8'h80, 1'b1);
    wait_idle("t3c_timeout");
    run_start(8'($urandom_range(255, 0)), 1'b1);
    wait_idle("t3d_timeout");

    // Test 4: start pulsed mid-run with exp 00 is ignored.
    base = ack_total;
    run_start(a5, 1'b1);
    wait_acks(base + 2, "t4_ack_timeout");
    cyc();
    start  = 1'b1;
    exp_in = 8'h00;
    cyc();
    start = 1'b0;
    wait_idle("t4_timeout");
    chk("t4_acks", 64'(ack_total - base), 64'd8);
    chk("t4_sb_drained", 64'(sb.size()), 64'd0);

    // Test 5: abort after four steps, then a clean run.
    rand_stall = 1'b0;
    fix_stall  = 1;
    base = ack_total;
    run_start(a5, 1'b0);
    wait_acks(base + 4, "t5_ack_timeout");
    abort = 1'b1;
    cyc();
    abort = 1'b0;
    chk("t5_req", 64'(step_req), 64'd0);
    chk("t5_busy", 64'(busy), 64'd0);
    chk("t5_valid", 64'(res_valid), 64'd0);
    repeat (5) cyc();
    chk("t5_valid_later", 64'(res_valid), 64'd0);
    run_start(8'h3C, 1'b1);
    wait_idle("t5_timeout");

    // Test 6: result held with ready low, then reset mid-run.
    res_ready = 1'b0;
    run_start(8'h11, 1'b1);
    n = 0;
    while (!res_valid && n < 400) begin
      cyc();
      n++;
    end
    chk("t6_valid_seen", 64'(res_valid), 64'd1);
    for (int i = 0; i < 10; i++) begin
      cyc();
      chk("t6_hold_valid", 64'(res_valid), 64'd1);
    end
    res_ready = 1'b1;
    wait_idle("t6_timeout");
    base = ack_total;
    run_start(8'hC3, 1'b0);
    wait_acks(base + 3, "t6_ack_timeout");
    rst = 1'b1;
    cyc();
    chk_reset_outs("t6_rst");
    rst = 1'b0;

    // Reset and start together: start is dropped.
    cyc();
    rst   = 1'b1;
    start = 1'b1;
    cyc();
    rst   = 1'b0;
    start = 1'b0;
    chk("rst_start_busy", 64'(busy), 64'd0);
    cyc();
    chk("rst_start_busy2", 64'(busy), 64'd0);
    chk("final_sb_empty", 64'(sb.size()), 64'd0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
